// File: rtl/acc_cmd_initiator.sv
// CPU-side initiator for the BNN accelerator MMIO command port: issues SRC, DES and
// START writes for one {src,dst} command, waits for busy to drop and returns the result.
module acc_cmd_initiator #(
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
  parameter logic [31:0] OFF_SRC   = 32'h0008_0000,
  parameter logic [31:0] OFF_DES   = 32'h000C_0000,
  parameter logic [31:0] OFF_START = 32'h0010_0000,
  parameter int unsigned SRC_GAP   = 1,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src,
  input  logic [31:0] cmd_dst,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic        mmio_wr,
  input  logic        acc_busy,
  input  logic [31:0] acc_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LOAD = (SRC_GAP == 0) ? 4'd0 : 4'(SRC_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SRC   = 3'd1,
    S_GAP      = 3'd2,
    S_WR_DES   = 3'd3,
    S_WR_START = 3'd4,
    S_WAIT     = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [3:0]        gap_q, gap_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       mmio_addr_q, mmio_addr_d;
  logic [31:0]       mmio_wdata_q, mmio_wdata_d;
  logic              mmio_wr_q, mmio_wr_d;
  logic              idle_q, idle_d;

  // idle_q keeps cmd_ready low while reset is asserted even though the state is IDLE
  assign cmd_ready  = idle_q & ~acc_busy;
  assign mmio_addr  = mmio_addr_q;
  assign mmio_wdata = mmio_wdata_q;
  assign mmio_wr    = mmio_wr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

  // Next-state logic, plus output values decoded from the next state so they register cleanly
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    gap_d        = gap_q;
    wait_d       = wait_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          state_d = S_WR_SRC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_SRC: begin
        if (SRC_GAP != 32'd0) begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end else begin
          state_d = S_WR_DES;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_WR_DES;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_WR_DES: begin
        state_d = S_WR_START;
      end
      S_WR_START: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A busy drop wins over a timeout landing on the same cycle
        if (!acc_busy) begin
          rsp_result_d = acc_result;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end else if (wait_q == CNT_LAST) begin
          rsp_result_d = 32'd0;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    mmio_addr_d  = BASE_ADDR;
    mmio_wdata_d = 32'd0;
    mmio_wr_d    = 1'b0;
    case (state_d)
      S_WR_SRC: begin
        mmio_addr_d  = BASE_ADDR | OFF_SRC;
        mmio_wdata_d = src_d;
        mmio_wr_d    = 1'b1;
      end
      S_WR_DES: begin
        mmio_addr_d  = BASE_ADDR | OFF_DES;
        mmio_wdata_d = dst_d;
        mmio_wr_d    = 1'b1;
      end
      S_WR_START: begin
        mmio_addr_d  = BASE_ADDR | OFF_START;
        mmio_wdata_d = 32'd0;
        mmio_wr_d    = 1'b1;
      end
      default: begin
        mmio_wr_d = 1'b0;
      end
    endcase

    idle_d      = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State, latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= 32'd0;
      dst_q        <= 32'd0;
      gap_q        <= 4'd0;
      wait_q       <= '0;
      rsp_result_q <= 32'd0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      mmio_addr_q  <= BASE_ADDR;
      mmio_wdata_q <= 32'd0;
      mmio_wr_q    <= 1'b0;
      idle_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      gap_q        <= gap_d;
      wait_q       <= wait_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_wr_q    <= mmio_wr_d;
      idle_q       <= idle_d;
    end
  end

endmodule
